alu_multiciclo: RTL and testbench

- Parametrised successor to the combinational ALU control/ALU pair in the datapath.
- Decodes UC_signal/func_code internally and executes single-cycle logic/arithmetic ops with a registered result.
- Adds iterative unsigned multiply and divide writing HI/LO registers, with a start/busy/done handshake.
- Sits in the EX stage of the multicycle datapath; the control unit stalls on busy.

---
 rtl/alu_multiciclo.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_multiciclo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multiciclo.sv
// alu_multiciclo: EX-stage ALU for the multicycle datapath.
// Decodes UC_signal/func_code internally. AND/OR/ADD/SUB/SLT complete one
// cycle after the accepted start. MULTU and DIVU iterate one bit per clock
// for WIDTH clocks and write HI/LO when they finish.
//
// Handshake: start is sampled only while the FSM is in IDLE. An accepted start
// on MULTU/DIVU (nonzero divisor) raises busy on the next cycle. busy stays
// high until the completion edge. done pulses for exactly one cycle when
// result/hi/lo are valid. A start while busy is ignored. A start in the done
// cycle is accepted, because the FSM is already back in IDLE.
module alu_multiciclo #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       UC_signal,
  input  logic [5:0]       func_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             illegal_op
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_SLT   = 3'd4,
    OP_MULTU = 3'd5,
    OP_DIVU  = 3'd6,
    OP_ILL   = 3'd7
  } op_t;

  state_t             state_q;
  op_t                dec_op;
  logic [WIDTH-1:0]   alu_res;
  logic [CNT_W-1:0]   cnt_q;
  logic               last_iter;

  // Iteration datapath, shared by multiply and divide:
  //  multiply: opnd_q = multiplicand, acc_hi = partial product high half,
  //            acc_lo = multiplier shifting out / product low half shifting in
  //  divide:   opnd_q = divisor, acc_hi = partial remainder,
  //            acc_lo = dividend shifting out / quotient shifting in
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_nx;
  logic [WIDTH-1:0]   mul_lo_nx;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   div_hi_nx;
  logic [WIDTH-1:0]   div_lo_nx;

  // Decode the operation from the control-unit class and the R-type funct.
  always_comb begin
    dec_op = OP_ILL;
    if (UC_signal == 3'b000) begin
      case (func_code)
        6'b000000: dec_op = OP_AND;
        6'b000001: dec_op = OP_OR;
        6'b000010: dec_op = OP_ADD;
        6'b000110: dec_op = OP_SUB;
        6'b000111: dec_op = OP_SLT;
        6'b011000: dec_op = OP_MULTU;
        6'b011010: dec_op = OP_DIVU;
        default:   dec_op = OP_ILL;
      endcase
    end else begin
      case (UC_signal)
        3'b001:  dec_op = OP_ADD;
        3'b010:  dec_op = OP_SUB;
        3'b011:  dec_op = OP_AND;
        3'b100:  dec_op = OP_OR;
        3'b101:  dec_op = OP_SLT;
        default: dec_op = OP_ILL;
      endcase
    end
  end

  // Single-cycle ALU function. ADD/SUB wrap, and SLT compares signed.
  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  // One shift-add multiply step: add the multiplicand when the multiplier LSB
  // is set, then shift the {acc_hi, acc_lo} pair right by one.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + ({1'b0, opnd_q} & {(WIDTH+1){acc_lo[0]}});
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
  end

  // One restoring-divide step: shift in the next dividend bit and subtract
  // the divisor. Keep the difference only when it did not go negative.
  always_comb begin
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = ~div_diff[WIDTH];
    div_hi_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo_nx = {acc_lo[WIDTH-2:0], div_ge};
  end

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  // Control FSM plus all registered outputs. done/illegal_op default low, so
  // each one is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      opnd_q      <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b1;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      done       <= 1'b0;
      illegal_op <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            cnt_q       <= '0;
            case (dec_op)
              OP_MULTU: begin
                opnd_q  <= op_a;
                acc_hi  <= '0;
                acc_lo  <= op_b;
                busy    <= 1'b1;
                state_q <= S_MUL;
              end
              OP_DIVU: begin
                if (op_b == '0) begin
                  // Divide by zero resolves at once with a MIPS-like result.
                  lo          <= '1;
                  hi          <= op_a;
                  result      <= '1;
                  zero        <= 1'b0;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                end else begin
                  opnd_q  <= op_b;
                  acc_hi  <= '0;
                  acc_lo  <= op_a;
                  busy    <= 1'b1;
                  state_q <= S_DIV;
                end
              end
              OP_ILL: begin
                result     <= '0;
                zero       <= 1'b1;
                illegal_op <= 1'b1;
                done       <= 1'b1;
              end
              default: begin
                result <= alu_res;
                zero   <= (alu_res == '0);
                done   <= 1'b1;
              end
            endcase
          end
        end

        S_MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi      <= mul_hi_nx;
            lo      <= mul_lo_nx;
            result  <= mul_lo_nx;
            zero    <= (mul_lo_nx == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        S_DIV: begin
          acc_hi <= div_hi_nx;
          acc_lo <= div_lo_nx;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_iter) begin
            hi      <= div_hi_nx;
            lo      <= div_lo_nx;
            result  <= div_lo_nx;
            zero    <= (div_lo_nx == '0);
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed testbench for alu_multiciclo. It uses a 32-bit instance for most
// vectors and an 8-bit instance for the small multiply.
module tb_alu_multiciclo;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 32-bit instance
  logic        start;
  logic [2:0]  uc;
  logic [5:0]  fn;
  logic [31:0] op_a, op_b;
  logic        busy, done, zero, div_by_zero, illegal_op;
  logic [31:0] result, hi, lo;

  alu_multiciclo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .UC_signal(uc), .func_code(fn),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
    .zero(zero), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .illegal_op(illegal_op)
  );

  // 8-bit instance
  logic       start8;
  logic [2:0] uc8;
  logic [5:0] fn8;
  logic [7:0] a8, b8;
  logic       busy8, done8, zero8, dbz8, ill8;
  logic [7:0] result8, hi8, lo8;

  alu_multiciclo #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .UC_signal(uc8), .func_code(fn8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .result(result8),
    .zero(zero8), .hi(hi8), .lo(lo8), .div_by_zero(dbz8), .illegal_op(ill8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard compare
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: pulse start for one cycle. Returns at the negedge after the
  // accept edge.
  task automatic issue(input logic [2:0] u, input logic [5:0] f,
                       input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    uc = u; fn = f; op_a = x; op_b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count cycles with busy high (bounded). Optionally pokes start with junk
  // operands while busy.
  task automatic wait_idle(input bit poke, output int cyc);
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (poke && (cyc % 4 == 0)) begin
        start = 1'b1; fn = 6'b000010; op_a = $urandom; op_b = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Simple R-type vectors with op_a=0xC and op_b=0xA.
  logic [5:0]  simple_fn  [5] = '{6'b000000, 6'b000001, 6'b000010, 6'b000110, 6'b000111};
  logic [31:0] simple_exp [5] = '{32'h8, 32'hE, 32'h16, 32'h2, 32'h0};

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; uc = '0; fn = '0; op_a = '0; op_b = '0;
    start8 = 1'b0; uc8 = '0; fn8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zero, 1);
    check("rst_result", result, 0);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_flags", {div_by_zero, illegal_op}, 0);
    rst_n = 1'b1;

    // simple R-type ops
    for (int i = 0; i < 5; i++) begin
      issue(3'b000, simple_fn[i], 32'hC, 32'hA);
      check($sformatf("rtype%0d_done", i), done, 1);
      check($sformatf("rtype%0d_result", i), result, simple_exp[i]);
    end
    @(negedge clk);
    check("done_pulse_one_cycle", done, 0);
    check("result_holds", result, 0);

    issue(3'b010, 6'b0, 32'd5, 32'd5);
    check("sub_eq_result", result, 0);
    check("sub_eq_zero", zero, 1);

    issue(3'b101, 6'b0, 32'hFFFFFFFF, 32'd1);
    check("slt_signed", result, 1);
    check("slt_zero", zero, 0);

    issue(3'b001, 6'b0, 32'hFFFFFFFF, 32'd1);
    check("add_wrap_result", result, 0);
    check("add_wrap_zero", zero, 1);

    // MULTU with start pokes while busy
    issue(3'b000, 6'b011000, 32'hFFFFFFFF, 32'd2);
    check("mul_busy_after_accept", busy, 1);
    check("mul_no_early_done", done, 0);
    wait_idle(1'b1, cyc);
    check("mul_busy_cycles", cyc, 32);
    check("mul_done", done, 1);
    check("mul_hi", hi, 32'h1);
    check("mul_lo", lo, 32'hFFFFFFFE);
    check("mul_result", result, 32'hFFFFFFFE);
    @(negedge clk);
    check("mul_pokes_ignored", {busy, done}, 0);

    // DIVU 100/7
    issue(3'b000, 6'b011010, 32'd100, 32'd7);
    wait_idle(1'b0, cyc);
    check("div_busy_cycles", cyc, 32);
    check("div_done", done, 1);
    check("div_lo", lo, 14);
    check("div_hi", hi, 2);
    check("div_result", result, 14);

    // DIVU by zero
    issue(3'b000, 6'b011010, 32'd5, 32'd0);
    check("dbz_done_busy", {done, busy}, 2'b10);
    check("dbz_lo", lo, 32'hFFFFFFFF);
    check("dbz_hi", hi, 5);
    check("dbz_result", result, 32'hFFFFFFFF);
    check("dbz_flag", div_by_zero, 1);
    @(negedge clk);
    check("dbz_sticky", div_by_zero, 1);

    issue(3'b001, 6'b0, 32'd1, 32'd2);
    check("dbz_clear", div_by_zero, 0);
    check("add_after_dbz", result, 3);

    // illegal ops
    issue(3'b000, 6'b101010, 32'd9, 32'd9);
    check("ill_func_result", result, 0);
    check("ill_func_flags", {illegal_op, done}, 2'b11);
    check("ill_func_hilo", {hi, lo}, {32'd5, 32'hFFFFFFFF});
    @(negedge clk);
    check("ill_pulse_one_cycle", {illegal_op, done}, 0);
    issue(3'b001, 6'b0, 32'd6, 32'd1);
    issue(3'b111, 6'b0, 32'd9, 32'd9);
    check("ill_uc_result", result, 0);
    check("ill_uc_flags", {illegal_op, done}, 2'b11);
    check("ill_uc_hilo", {hi, lo}, {32'd5, 32'hFFFFFFFF});

    // reset in the middle of a MULTU
    issue(3'b001, 6'b0, 32'd10, 32'd20);
    check("pre_reset_add", result, 30);
    issue(3'b000, 6'b011000, 32'h1234, 32'h5678);
    repeat (9) @(negedge clk);
    check("mul_still_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy_done", {busy, done}, 0);
    check("midrst_result_zero", {result, zero}, {32'd0, 1'b1});
    check("midrst_hilo", {hi, lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b001, 6'b0, 32'd3, 32'd4);
    check("post_rst_add", result, 7);
    check("post_rst_done_busy", {done, busy}, 2'b10);
    check("post_rst_hilo", {hi, lo}, 0);

    // MULTU 13 x 11 on the 8-bit instance
    @(negedge clk);
    uc8 = 3'b000; fn8 = 6'b011000; a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    cyc = 0;
    while (busy8 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("mul8_busy_cycles", cyc, 8);
    check("mul8_done", done8, 1);
    check("mul8_hilo", {hi8, lo8}, 16'h008F);
    check("mul8_result", result8, 8'h8F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
